// File: rtl/orbit_pkg.sv
// orbit_pkg
//   Shared definitions for the orbit step scheduler:
//   - DEF_SCREEN_W / DEF_SCREEN_H : default screen size in pixels.
//   - KEY_* : bit positions inside the 4-bit key vector.
//   - vel_t : signed 16-bit velocity.
//   - orbit_state_t : per-frame sequencer states.
package orbit_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  localparam int KEY_UP      = 0;
  localparam int KEY_DOWN    = 1;
  localparam int KEY_FIRE    = 2;
  localparam int KEY_RESTART = 3;

  typedef logic signed [15:0] vel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_RSQ,
    S_DIV_F,
    S_DIV_AX,
    S_DIV_AY,
    S_UPDATE,
    S_DONE
  } orbit_state_t;

endpackage

// File: rtl/orbit_step_scheduler_if.sv
// orbit_step_scheduler_if
//   Frame/key inputs and ship state/status outputs of the scheduler.
//   master : the frame source and display side (drives frame_tick, keys).
//   slave  : the scheduler (drives ship position, velocity and flags).
interface orbit_step_scheduler_if;
  import orbit_pkg::*;

  logic        frame_tick;
  logic [3:0]  keys;
  logic [15:0] ship_x;
  logic [15:0] ship_y;
  vel_t        vel_x;
  vel_t        vel_y;
  logic        step_busy;
  logic        step_done;
  logic        fire;
  logic        crash;
  logic        overrun;

  modport master (
    output frame_tick, keys,
    input  ship_x, ship_y, vel_x, vel_y, step_busy, step_done, fire, crash, overrun
  );

  modport slave (
    input  frame_tick, keys,
    output ship_x, ship_y, vel_x, vel_y, step_busy, step_done, fire, crash, overrun
  );

endinterface

// File: rtl/seq_divider.sv
// seq_divider
//   Restoring unsigned divider producing one quotient bit per cycle.
//   Ports: clk, reset (async, active-low); start pulse loads dividend and
//   divisor; busy is high while iterating; done pulses for one cycle with
//   quotient valid. Division by zero yields all-ones.
module seq_divider #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DIV_W:0]   trial;
  logic [DIV_W-1:0] diff;

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    // Shift the next dividend bit into the partial remainder.
    trial  = {rem_q, quot_q[DIV_W-1]};
    // Only used when trial >= divisor, so the result fits in DIV_W bits.
    diff   = trial[DIV_W-1:0] - dvs_q;
    if (start && !busy_q) begin
      rem_d  = '0;
      quot_d = dividend;
      dvs_d  = divisor;
      cnt_d  = CNT_W'(DIV_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d  = diff;
        quot_d = {quot_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d  = trial[DIV_W-1:0];
        quot_d = {quot_q[DIV_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quot_q;

endmodule

// File: rtl/orbit_step_scheduler.sv
// orbit_step_scheduler
//   Per-frame gravity step for the ship. A frame_tick latches the keys and
//   runs CAPTURE -> RSQ -> DIV_F -> DIV_AX -> DIV_AY -> UPDATE -> DONE, with
//   all three divisions sharing one seq_divider.
//   Ports: clk, reset (async, active-low), bus (slave side of
//   orbit_step_scheduler_if: frame_tick/keys in; ship_x/y, vel_x/y,
//   step_busy, step_done, fire, crash, overrun out).
module orbit_step_scheduler
  import orbit_pkg::*;
#(
  parameter int          SCREEN_W = DEF_SCREEN_W,
  parameter int          SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned GM       = 100000,
  parameter int          THRUST   = 2,
  parameter int          VMAX     = 64,
  parameter int          R_MIN_SQ = 64,
  parameter int          DIV_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  orbit_step_scheduler_if.slave        bus
);
  localparam int SUM_W = DIV_W + 4;

  orbit_state_t            state_q, state_d;
  logic [3:0]              keys_q, keys_d;
  logic [15:0]             x_q, x_d, y_q, y_d;
  vel_t                    vx_q, vx_d, vy_q, vy_d;
  logic signed [16:0]      dx_q, dx_d, dy_q, dy_d;
  logic [DIV_W-1:0]        rsq_q, rsq_d, f_q, f_d;
  logic signed [DIV_W:0]   ax_q, ax_d, ay_q, ay_d;
  logic                    busy_q, busy_d, done_q, done_d, fire_q, fire_d;
  logic                    crash_q, crash_d, ovr_q, ovr_d;

  logic                    div_start, div_busy, div_done;
  logic [DIV_W-1:0]        div_dividend, div_divisor, div_quot;

  logic [16:0]             abs_dx, abs_dy;
  logic [DIV_W-1:0]        rsq_c;
  logic signed [DIV_W:0]   quot_s;
  logic signed [SUM_W-1:0] vx_sum, vy_sum;
  vel_t                    vx_new, vy_new;
  logic signed [17:0]      px, py;

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  function automatic vel_t sat_vel(input logic signed [SUM_W-1:0] v);
    if (v > SUM_W'(VMAX))       return vel_t'(VMAX);
    else if (v < -SUM_W'(VMAX)) return vel_t'(-VMAX);
    else                        return vel_t'(v);
  endfunction

  // Datapath: distances, r^2, signed quotient, velocity and wrapped position.
  always_comb begin
    abs_dx = dx_q[16] ? -dx_q : dx_q;
    abs_dy = dy_q[16] ? -dy_q : dy_q;
    rsq_c  = DIV_W'(abs_dx) * DIV_W'(abs_dx) + DIV_W'(abs_dy) * DIV_W'(abs_dy);
    quot_s = $signed({1'b0, div_quot});
    vx_sum = SUM_W'(vx_q) + SUM_W'(ax_q);
    vy_sum = SUM_W'(vy_q) + SUM_W'(ay_q);
    // Up and down thrust both applied cancel each other.
    if (keys_q[KEY_UP])   vy_sum = vy_sum - SUM_W'(THRUST);
    if (keys_q[KEY_DOWN]) vy_sum = vy_sum + SUM_W'(THRUST);
    vx_new = sat_vel(vx_sum);
    vy_new = sat_vel(vy_sum);
    // |v| <= VMAX keeps the sum within one screen of the visible range,
    // so a single wrap is enough.
    px = $signed({2'b00, x_q}) + 18'(vx_new);
    py = $signed({2'b00, y_q}) + 18'(vy_new);
    if (px < 0)                   px = px + 18'(SCREEN_W);
    else if (px >= 18'(SCREEN_W)) px = px - 18'(SCREEN_W);
    if (py < 0)                   py = py + 18'(SCREEN_H);
    else if (py >= 18'(SCREEN_H)) py = py - 18'(SCREEN_H);
  end

  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    rsq_d   = rsq_q;
    f_d     = f_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    crash_d = crash_q;
    ovr_d   = ovr_q;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;

    // Any tick outside IDLE (including the DONE cycle) is dropped.
    if (bus.frame_tick && state_q != S_IDLE) ovr_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_tick) begin
          keys_d  = ~bus.keys;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (keys_q[KEY_RESTART]) begin
          x_d     = 16'(SCREEN_W / 2);
          y_d     = 16'(SCREEN_H / 2);
          vx_d    = '0;
          vy_d    = '0;
          state_d = S_DONE;
        end else begin
          dx_d    = 17'(SCREEN_W / 2) - $signed({1'b0, x_q});
          dy_d    = 17'(SCREEN_H / 2) - $signed({1'b0, y_q});
          state_d = S_RSQ;
        end
      end
      S_RSQ: begin
        rsq_d = rsq_c;
        if (rsq_c < DIV_W'(R_MIN_SQ)) crash_d = 1'b1;
        if (rsq_c == '0) begin
          ax_d    = '0;
          ay_d    = '0;
          state_d = S_UPDATE;
        end else if (!div_busy) begin
          div_start    = 1'b1;
          div_dividend = DIV_W'(GM);
          div_divisor  = rsq_c;
          state_d      = S_DIV_F;
        end
      end
      // Each division launches the next in its done cycle, so every DIV
      // state lasts exactly DIV_W+1 cycles.
      S_DIV_F: begin
        if (div_done) begin
          f_d          = div_quot;
          div_start    = 1'b1;
          div_dividend = div_quot * DIV_W'(abs_dx);
          div_divisor  = rsq_q;
          state_d      = S_DIV_AX;
        end
      end
      S_DIV_AX: begin
        if (div_done) begin
          ax_d         = dx_q[16] ? -quot_s : quot_s;
          div_start    = 1'b1;
          div_dividend = f_q * DIV_W'(abs_dy);
          div_divisor  = rsq_q;
          state_d      = S_DIV_AY;
        end
      end
      S_DIV_AY: begin
        if (div_done) begin
          ay_d    = dy_q[16] ? -quot_s : quot_s;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        vx_d    = vx_new;
        vy_d    = vy_new;
        x_d     = px[15:0];
        y_d     = py[15:0];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    fire_d = done_d & keys_q[KEY_FIRE];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      keys_q  <= '0;
      x_q     <= 16'(SCREEN_W / 2);
      y_q     <= 16'(SCREEN_H / 2);
      vx_q    <= '0;
      vy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      rsq_q   <= '0;
      f_q     <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fire_q  <= 1'b0;
      crash_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      rsq_q   <= rsq_d;
      f_q     <= f_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fire_q  <= fire_d;
      crash_q <= crash_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.ship_x    = x_q;
  assign bus.ship_y    = y_q;
  assign bus.vel_x     = vx_q;
  assign bus.vel_y     = vy_q;
  assign bus.step_busy = busy_q;
  assign bus.step_done = done_q;
  assign bus.fire      = fire_q;
  assign bus.crash     = crash_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_orbit_step_scheduler.sv
// tb_orbit_step_scheduler
//   Drives random key patterns frame by frame and compares the scheduler
//   against an arithmetic model of the orbital step; also covers reset
//   values, the centre (r_sq == 0) step, overrun and reset during a step.
module tb_orbit_step_scheduler;
  import orbit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  orbit_step_scheduler_if bus_if();

  orbit_step_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state of the ship.
  longint mx, my, mvx, mvy;
  bit     mcrash, movr;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampv(input longint v);
    if (v > 64)  return 64;
    if (v < -64) return -64;
    return v;
  endfunction

  function automatic longint wrapp(input longint p, input longint m);
    if (p < 0)  return p + m;
    if (p >= m) return p - m;
    return p;
  endfunction

  // a = sign(d) * (((f*|d|) mod 2^32) / r_sq)
  function automatic longint accel(input longint d, input longint f, input longint rsq);
    longint ad, mag;
    ad  = (d < 0) ? -d : d;
    mag = ((f * ad) & 64'hFFFF_FFFF) / rsq;
    return (d < 0) ? -mag : mag;
  endfunction

  function automatic longint pred_rsq();
    return (320 - mx) * (320 - mx) + (240 - my) * (240 - my);
  endfunction

  // One frame of the reference; act is the active-high key vector.
  task automatic model_step(input logic [3:0] act, output int lat, output bit is_restart);
    longint dx, dy, rsq, f, ax, ay, vy;
    is_restart = act[KEY_RESTART];
    lat = 0;
    if (is_restart) begin
      mx = 320; my = 240; mvx = 0; mvy = 0;
    end else begin
      dx  = 320 - mx;
      dy  = 240 - my;
      rsq = dx * dx + dy * dy;
      if (rsq < 64) mcrash = 1'b1;
      if (rsq == 0) begin
        ax = 0; ay = 0; lat = 4;
      end else begin
        f  = 100000 / rsq;
        ax = accel(dx, f, rsq);
        ay = accel(dy, f, rsq);
        lat = 103;
      end
      mvx = clampv(mvx + ax);
      vy  = mvy + ay;
      if (act[KEY_UP])   vy = vy - 2;
      if (act[KEY_DOWN]) vy = vy + 2;
      mvy = clampv(vy);
      mx  = wrapp(mx + mvx, 640);
      my  = wrapp(my + mvy, 480);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " ship_x"},  bus_if.ship_x,  mx);
    chk({tag, " ship_y"},  bus_if.ship_y,  my);
    chk({tag, " vel_x"},   bus_if.vel_x,   mvx);
    chk({tag, " vel_y"},   bus_if.vel_y,   mvy);
    chk({tag, " crash"},   bus_if.crash,   mcrash);
    chk({tag, " overrun"}, bus_if.overrun, movr);
  endtask

  task automatic run_step(input string tag, input logic [3:0] act);
    int lat_exp, cyc;
    bit is_restart, seen;
    model_step(act, lat_exp, is_restart);
    @(negedge clk);
    bus_if.keys       = ~act;
    bus_if.frame_tick = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      bus_if.frame_tick = 1'b0;
      cyc++;
      if (bus_if.step_done) seen = 1'b1;
    end
    chk({tag, " done_seen"}, seen, 1);
    if (!is_restart) chk({tag, " latency"}, cyc, lat_exp);
    chk_state(tag);
    chk({tag, " fire"}, bus_if.fire, act[KEY_FIRE]);
    chk({tag, " busy_in_done"}, bus_if.step_busy, 1);
    @(posedge clk);
    #1;
    chk({tag, " busy_after"}, bus_if.step_busy, 0);
    chk({tag, " done_after"}, bus_if.step_done, 0);
    bus_if.keys = 4'hF;
    $display("step %s keys=%b lat=%0d x=%0d y=%0d vx=%0d vy=%0d crash=%0d",
             tag, act, cyc, bus_if.ship_x, bus_if.ship_y, bus_if.vel_x,
             bus_if.vel_y, bus_if.crash);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ship_x"},  bus_if.ship_x,    320);
    chk({tag, " ship_y"},  bus_if.ship_y,    240);
    chk({tag, " vel_x"},   bus_if.vel_x,     0);
    chk({tag, " vel_y"},   bus_if.vel_y,     0);
    chk({tag, " busy"},    bus_if.step_busy, 0);
    chk({tag, " done"},    bus_if.step_done, 0);
    chk({tag, " fire"},    bus_if.fire,      0);
    chk({tag, " crash"},   bus_if.crash,     0);
    chk({tag, " overrun"}, bus_if.overrun,   0);
  endtask

  initial begin
    logic [3:0] act;
    int lat_exp, ndone, first_done;
    bit rs;

    reset             = 1'b0;
    bus_if.frame_tick = 1'b0;
    bus_if.keys       = 4'hF;
    mx = 320; my = 240; mvx = 0; mvy = 0; mcrash = 1'b0; movr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;

    // Ship at the centre: r_sq == 0, short path, crash set.
    run_step("center", 4'b0000);

    for (int i = 0; i < 60; i++) begin
      act[KEY_UP]      = 1'($urandom_range(0, 1));
      act[KEY_DOWN]    = ($urandom_range(0, 3) == 0);
      act[KEY_FIRE]    = 1'($urandom_range(0, 1));
      act[KEY_RESTART] = ($urandom_range(0, 15) == 0);
      run_step($sformatf("rnd%0d", i), act);
    end

    // Make sure the next step takes the long (three-division) path.
    for (int i = 0; i < 10 && pred_rsq() == 0; i++)
      run_step($sformatf("offcenter%0d", i), 4'b0001);

    // Second tick 50 cycles into a step: dropped, overrun set, one step_done.
    model_step(4'b0000, lat_exp, rs);
    movr       = 1'b1;
    ndone      = 0;
    first_done = 0;
    @(negedge clk);
    bus_if.frame_tick = 1'b1;
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk);
      #1;
      bus_if.frame_tick = (c == 50);
      if (bus_if.step_done) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
    end
    bus_if.frame_tick = 1'b0;
    chk("ovr done_count", ndone, 1);
    chk("ovr latency", first_done, lat_exp);
    chk_state("ovr");
    chk("ovr busy_idle", bus_if.step_busy, 0);
    $display("step overrun done_count=%0d lat=%0d overrun=%0d",
             ndone, first_done, bus_if.overrun);

    // Reset 60 cycles into a step: step aborted, everything back to reset values.
    @(negedge clk);
    bus_if.frame_tick = 1'b1;
    repeat (60) begin
      @(posedge clk);
      #1;
      bus_if.frame_tick = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk_reset_vals("midreset");
    $display("step midreset x=%0d y=%0d busy=%0d", bus_if.ship_x, bus_if.ship_y,
             bus_if.step_busy);
    mx = 320; my = 240; mvx = 0; mvy = 0; mcrash = 1'b0; movr = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_step("post_reset", 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
